pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Arbitrates between three sources, in priority order: variable-latency data-memory wait, taken branch in EX, load-use hazard in ID.
- Sits beside the pipeline registers and is fed from ID decode, ID/EX contents, the EX branch comparator and the data-memory handshake.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before declaring a memory error (2..255).
- REG_ADDR_W, 5, register-address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  REG_ADDR_W  rs of instruction in ID.
- id_rt  in  REG_ADDR_W  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- ex_rd  in  REG_ADDR_W  destination of instruction in ID/EX.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ack  in  1  data memory completes access this cycle.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads bubble (control signals zero).
- ex_mem_en  out  1  EX/MEM load enable.
- mem_wb_bubble  out  1  MEM/WB loads zero control signals.
- mem_err  out  1  sticky memory-timeout flag.
- busy  out  1  state != RUN.

Behaviour:
- States: RUN, MEM_WAIT, HALT. State and wait counter are registered; outputs are combinational from state and inputs.
- While reset=1:
  - Enables pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - Flushes if_id_flush, id_ex_flush, mem_wb_bubble = 1.
  - mem_err=0, busy=0.
  - On the next edge with reset=1: state<=RUN, counter<=0.
- Reset mid-operation aborts any wait immediately.
- RUN, default (no hazard): all enables 1, all flush/bubble 0.
- RUN, mem_req & !mem_ack (priority 1):
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_bubble=1.
  - Branch and load-use are ignored this cycle.
  - Next state MEM_WAIT; counter<=1.
- RUN, mem_req & mem_ack same cycle: zero-wait access; no stall.
- RUN, ex_branch_taken, no memory stall (priority 2):
  - pc_en=1 (loads target).
  - if_id_flush=1, id_ex_flush=1.
  - Load-use is ignored, because the ID instruction is squashed.
  - State stays RUN.
- RUN, load-use (priority 3). Hazard = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - Exactly one bubble; the condition clears naturally on the next cycle.
- MEM_WAIT: same freeze outputs as the RUN memory-stall case; busy=1.
  - mem_ack=1: outputs stay frozen this cycle; next state RUN; counter<=0.
  - Otherwise counter increments.
  - counter==MEM_TIMEOUT & !mem_ack: next state HALT; mem_err<=1.
- Branch during memory stall: the branch stays held in ID/EX and is acted on in the first RUN cycle after the ack.
- HALT: all enables 0, all flushes 1, busy=1, mem_err=1. Exit only via reset.
- Counter width is 8 bits; it saturates and never wraps.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both cleared by reset.
  - perf_stall_cycles increments on each cycle with pc_en=0 outside reset.
  - perf_flush_count increments on each branch-flush cycle.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2);
  - REG_ADDR_W default;
  - ZERO_REG constant.
- One sub-module: hazard_detect. It is the combinational load-use comparator, reused later by the forwarding unit.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 for one cycle -> if_id_flush=id_ex_flush=1, pc_en=1. Same cycle with a load-use match -> flush only, no stall.
- Memory wait: mem_req=1 with mem_ack delayed 3 cycles -> 3 frozen cycles in MEM_WAIT plus the ack cycle, mem_wb_bubble=1 throughout, then RUN.
- Branch held during memory wait: ex_branch_taken=1 with mem_req=1 and ack after 2 cycles -> flush occurs in the first cycle after return to RUN.
- Timeout with MEM_TIMEOUT=4 and mem_ack never asserted -> HALT after 4 wait cycles, mem_err=1. Assert reset -> next cycle RUN, mem_err=0.
- With PIPE_HAZARD_PERF_EN: sequence of 1 load-use, 1 branch and 3 memory waits -> perf_stall_cycles=5, perf_flush_count=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  // Register 0 is hardwired to zero, so writes to it never create a hazard.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// Optional perf counters appear when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W_DEF
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ack;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_en;
  logic                  id_ex_flush;
  logic                  ex_mem_en;
  logic                  mem_wb_bubble;
  logic                  mem_err;
  logic                  busy;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]           perf_stall_cycles;
  logic [31:0]           perf_flush_count;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, ex_branch_taken,
           mem_req, mem_ack,
`ifdef PIPE_HAZARD_PERF_EN
    input  perf_stall_cycles, perf_flush_count,
`endif
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, mem_err, busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, ex_branch_taken,
           mem_req, mem_ack,
`ifdef PIPE_HAZARD_PERF_EN
    output perf_stall_cycles, perf_flush_count,
`endif
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_bubble, mem_err, busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: the ID instruction reads a register
// that the load in ID/EX has not yet produced.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  // Match rs always, rt only when the ID instruction actually reads it.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(ZERO_REG)) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Priority: memory wait > taken branch > load-use.
// Optional perf counters are enabled by PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  pipe_hazard_ctrl_if.slave bus
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       load_use;
  logic       branch_flush;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, mem_wb_bubble, busy;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .load_use    (load_use)
  );

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    err_q   <= err_d;
  end

  // Next-state and pipeline-control outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    busy          = 1'b0;
    branch_flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ack) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          cnt_d         = 8'd1;
        end else if (bus.ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Pipeline stays frozen through the ack cycle too; a branch held in
        // ID/EX is therefore acted on in the first RUN cycle afterwards.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
        busy          = 1'b1;
        if (bus.mem_ack) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == 8'(MEM_TIMEOUT)) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HALT: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b1;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b1;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
        busy          = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      state_d       = RUN;
      cnt_d         = '0;
      err_d         = 1'b0;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
      busy          = 1'b0;
      branch_flush  = 1'b0;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.mem_wb_bubble = mem_wb_bubble;
  assign bus.mem_err       = err_q && !reset;
  assign bus.busy          = busy;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating perf counters.
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  // Count stalled-PC cycles and branch flushes outside reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (branch_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = stall_cnt_q;
  assign bus.perf_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_bubble,mem_err,busy}
  localparam logic [8:0] E_RUN  = 9'b1_1_0_1_0_1_0_0_0;
  localparam logic [8:0] E_RST  = 9'b0_0_1_0_1_0_1_0_0;
  localparam logic [8:0] E_FRZ  = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] E_WAIT = 9'b0_0_0_0_0_0_1_0_1;
  localparam logic [8:0] E_BR   = 9'b1_1_1_1_1_1_0_0_0;
  localparam logic [8:0] E_LU   = 9'b0_0_0_1_1_1_0_0_0;
  localparam logic [8:0] E_HALT = 9'b0_0_1_0_1_0_1_1_1;

  typedef struct {
    logic [8:0] exp;
    string      nm;
  } sb_entry_t;

  sb_entry_t sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic cyc(input logic rst, input logic rq, input logic ack,
                     input logic br, input logic mrd, input logic [4:0] rd,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic [8:0] exp, input string nm);
    sb_entry_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.mem_req         = rq;
    bus.mem_ack         = ack;
    bus.ex_branch_taken = br;
    bus.ex_mem_read     = mrd;
    bus.ex_rd           = rd;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rt      = urt;
    e.exp = exp;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input string nm);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN, nm);
  endtask

  // Monitor: compare one expected vector per cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      logic [8:0] got;
      e = sb.pop_front();
      got = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
             bus.id_ex_flush, bus.ex_mem_en, bus.mem_wb_bubble, bus.mem_err,
             bus.busy};
      n_total++;
      if (got !== e.exp)
        $display("FAIL %s: got %b expected %b", e.nm, got, e.exp);
      else
        n_pass++;
    end
  end

  initial begin
    bus.mem_req         = 1'b0;
    bus.mem_ack         = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = '0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_uses_rt      = 1'b0;

    //   rst   rq    ack   br    mrd   rd     rs     rt     urt   expect
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RST,  "reset0");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RST,  "reset1");
    idle("run_idle");
    // Load-use on rs, then cleared
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd0,  1'b0, E_LU,   "lu_rs");
    idle("lu_clear");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, E_RUN,  "lu_r0");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  5'd1,  5'd9,  1'b1, E_LU,   "lu_rt");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  5'd1,  5'd9,  1'b0, E_RUN,  "lu_rt_unused");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  5'd8,  5'd0,  1'b0, E_RUN,  "not_load");
    // Branch, and branch beating load-use
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_BR,   "branch");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  5'd8,  5'd0,  1'b0, E_BR,   "branch_lu");
    // Zero-wait memory access
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RUN,  "mem_zero_wait");
    // Memory wait with late ack; load-use ignored while stalling
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd0,  1'b0, E_FRZ,  "mem_stall");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "mem_wait1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "mem_wait2");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "mem_ack");
    idle("mem_back_run");
    // Branch held during memory wait
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_FRZ,  "brw_stall");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "brw_wait");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "brw_ack");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_BR,   "brw_flush");
    idle("brw_done");
    // Timeout: four wait cycles without ack, then HALT
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_FRZ,  "to_stall");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "to_wait1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "to_wait2");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "to_wait3");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "to_wait4");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_HALT, "halt0");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_HALT, "halt1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RST,  "halt_reset");
    idle("after_halt_run");
    // Reset aborting a memory wait
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_FRZ,  "ab_stall");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "ab_wait");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RST,  "ab_reset");
    idle("ab_run");

`ifdef PIPE_HAZARD_PERF_EN
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_RST,  "pf_reset");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  5'd0,  1'b0, E_LU,   "pf_lu");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_BR,   "pf_br");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_FRZ,  "pf_stall");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "pf_wait1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "pf_wait2");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, E_WAIT, "pf_ack");
    idle("pf_done");
    @(posedge clk);
    #1;
    n_total++;
    if (bus.perf_stall_cycles !== 32'd5)
      $display("FAIL perf_stall: got %0d expected 5", bus.perf_stall_cycles);
    else
      n_pass++;
    n_total++;
    if (bus.perf_flush_count !== 32'd1)
      $display("FAIL perf_flush: got %0d expected 1", bus.perf_flush_count);
    else
      n_pass++;
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached expected finish");
    $fatal(1, "watchdog");
  end

endmodule
